// File: rtl/wave_ctrl.sv
// wave_ctrl: key-driven configuration controller for the four-waveform ROM generator.
// Debounces three active-low keys and owns the waveform select, amplitude shift
// and phase-step registers. It also runs an up/down frequency-sweep sequencer
// on the phase step.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   key1, key2, key3  raw active-low keys (asynchronous to clk)
//   wave_sel          0 sin, 1 square, 2 sawtooth, 3 triangular
//   amp_shift         right shift applied to the waveform sample
//   phase_step        address increment per clk, never 0
//   sweep_active      high while the sweep sequencer is in UP or DOWN
//   cfg_update        one-cycle pulse the cycle after any control register changes
module wave_ctrl #(
    parameter int unsigned DEB_CNT     = 1000000,
    parameter int unsigned LONG_CNT    = 50000000,
    parameter int unsigned SWEEP_DWELL = 5000000,
    parameter int unsigned STEP_MAX    = 16,
    parameter int unsigned AMP_MAX     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    output logic [1:0] wave_sel,
    output logic [2:0] amp_shift,
    output logic [7:0] phase_step,
    output logic       sweep_active,
    output logic       cfg_update
);

    localparam int unsigned DEB_W  = (DEB_CNT > 1)     ? $clog2(DEB_CNT)     : 1;
    localparam int unsigned HOLD_W = (LONG_CNT > 1)    ? $clog2(LONG_CNT)    : 1;
    localparam int unsigned DW_W   = (SWEEP_DWELL > 1) ? $clog2(SWEEP_DWELL) : 1;
    localparam int unsigned CFG_W  = 13;

    localparam logic [7:0] STEP_TOP = 8'(STEP_MAX);
    localparam logic [2:0] AMP_TOP  = 3'(AMP_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    // Key paths, bit 0 = key1, bit 1 = key2, bit 2 = key3
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       acc_q;
    logic [2:0]       acc_d_q;
    logic [DEB_W-1:0] deb_cnt_q [3];
    logic [2:0]       press_ev;
    logic [2:0]       release_ev;

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              long_done_q;
    logic              long_ev;
    logic              short_ev;

    state_t            state_q;
    state_t            state_d;
    logic [DW_W-1:0]   dwell_q;
    logic [DW_W-1:0]   dwell_d;
    logic              dwell_tick;
    logic [7:0]        step_d;
    logic [CFG_W-1:0]  cfg_prev_q;

    // Synchronizers and debouncers for all three keys
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 3'b111;
            sync_q2 <= 3'b111;
            acc_q   <= 3'b111;
            acc_d_q <= 3'b111;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync_q1 <= {key3, key2, key1};
            sync_q2 <= sync_q1;
            acc_d_q <= acc_q;
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == acc_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CNT - 1)) begin
                    acc_q[i]     <= sync_q2[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= DEB_W'(deb_cnt_q[i] + 1'b1);
                end
            end
        end
    end

    assign press_ev   = acc_d_q & ~acc_q;
    assign release_ev = ~acc_d_q & acc_q;

    // key3 hold timer; the long event fires once while the key is still held
    assign long_ev  = !acc_q[2] && !press_ev[2] && !long_done_q &&
                      (hold_cnt_q == HOLD_W'(LONG_CNT - 1));
    assign short_ev = release_ev[2] && !long_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
        end else if (press_ev[2]) begin
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
        end else begin
            if (long_ev) long_done_q <= 1'b1;
            if (!acc_q[2] && (hold_cnt_q != HOLD_W'(LONG_CNT - 1)))
                hold_cnt_q <= HOLD_W'(hold_cnt_q + 1'b1);
        end
    end

    assign dwell_tick = (dwell_q == DW_W'(SWEEP_DWELL - 1));

    // Sweep sequencer next state and phase-step next value
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        step_d  = phase_step;
        case (state_q)
            S_IDLE: begin
                if (long_ev) begin
                    state_d = S_UP;
                    dwell_d = '0;
                end else if (short_ev) begin
                    step_d = (phase_step >= STEP_TOP) ? 8'd1 : 8'(phase_step + 8'd1);
                end
            end
            S_UP: begin
                if (long_ev) begin
                    state_d = S_IDLE;
                end else if (dwell_tick) begin
                    dwell_d = '0;
                    // Entering UP already at the top turns straight around
                    if (phase_step < STEP_TOP) begin
                        step_d = 8'(phase_step + 8'd1);
                        if (step_d == STEP_TOP) state_d = S_DOWN;
                    end else begin
                        step_d  = 8'(phase_step - 8'd1);
                        state_d = S_DOWN;
                    end
                end else begin
                    dwell_d = DW_W'(dwell_q + 1'b1);
                end
            end
            S_DOWN: begin
                if (long_ev) begin
                    state_d = S_IDLE;
                end else if (dwell_tick) begin
                    dwell_d = '0;
                    if (phase_step > 8'd1) begin
                        step_d = 8'(phase_step - 8'd1);
                        if (step_d == 8'd1) state_d = S_UP;
                    end else begin
                        step_d  = 8'(phase_step + 8'd1);
                        state_d = S_UP;
                    end
                end else begin
                    dwell_d = DW_W'(dwell_q + 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, sequencer state and change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dwell_q      <= '0;
            wave_sel     <= 2'd0;
            amp_shift    <= 3'd0;
            phase_step   <= 8'd1;
            sweep_active <= 1'b0;
            cfg_prev_q   <= {2'd0, 3'd0, 8'd1};
            cfg_update   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            phase_step   <= step_d;
            sweep_active <= (state_d != S_IDLE);
            if (press_ev[0]) wave_sel <= 2'(wave_sel + 2'd1);
            if (press_ev[1]) amp_shift <= (amp_shift >= AMP_TOP) ? 3'd0 : 3'(amp_shift + 3'd1);
            cfg_prev_q   <= {wave_sel, amp_shift, phase_step};
            cfg_update   <= ({wave_sel, amp_shift, phase_step} != cfg_prev_q);
        end
    end

endmodule

// File: tb/tb_wave_ctrl.sv
module tb_wave_ctrl;

    localparam int DEB_CNT     = 4;
    localparam int LONG_CNT    = 16;
    localparam int SWEEP_DWELL = 8;
    localparam int STEP_MAX    = 4;
    localparam int AMP_MAX     = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key1, key2, key3;
    logic [1:0] wave_sel;
    logic [2:0] amp_shift;
    logic [7:0] phase_step;
    logic       sweep_active;
    logic       cfg_update;

    int n_tests = 0;
    int n_fail  = 0;
    int cfg_pulses = 0;
    bit sweep_seen = 1'b0;

    // Behavioural model of the control registers
    int m_wave = 0;
    int m_amp  = 0;
    int m_step = 1;

    wave_ctrl #(
        .DEB_CNT(DEB_CNT), .LONG_CNT(LONG_CNT), .SWEEP_DWELL(SWEEP_DWELL),
        .STEP_MAX(STEP_MAX), .AMP_MAX(AMP_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key1(key1), .key2(key2), .key3(key3),
        .wave_sel(wave_sel), .amp_shift(amp_shift), .phase_step(phase_step),
        .sweep_active(sweep_active), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    task automatic step_clk(input int n);
        repeat (n) begin
            @(negedge clk);
            if (cfg_update) cfg_pulses++;
            if (sweep_active) sweep_seen = 1'b1;
        end
    endtask

    function automatic int sweep_model(input int t);
        int v = 1;
        int dir = 1;
        for (int k = 0; k < t / SWEEP_DWELL; k++) begin
            v += dir;
            if (v == STEP_MAX) dir = -1;
            else if (v == 1) dir = 1;
        end
        return v;
    endfunction

    function automatic void model_press(input logic [2:0] mask);
        if (mask[0]) m_wave = (m_wave + 1) % 4;
        if (mask[1]) m_amp  = (m_amp == AMP_MAX) ? 0 : m_amp + 1;
        if (mask[2]) m_step = (m_step == STEP_MAX) ? 1 : m_step + 1;
    endfunction

    task automatic do_press(input logic [2:0] mask, input int hold, input int gap);
        key1 = ~mask[0]; key2 = ~mask[1]; key3 = ~mask[2];
        step_clk(hold);
        key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        step_clk(gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        step_clk(3);
        n_tests++;
        if ({wave_sel, amp_shift, phase_step, sweep_active, cfg_update} !== {2'd0, 3'd0, 8'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got ws=%0d amp=%0d step=%0d sw=%0b cfg=%0b expected 0 0 1 0 0",
                     wave_sel, amp_shift, phase_step, sweep_active, cfg_update);
        end
        rst_n = 1'b1;
        step_clk(6);
        n_tests++;
        if ({wave_sel, amp_shift, phase_step, sweep_active, cfg_update} !== {2'd0, 3'd0, 8'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got ws=%0d amp=%0d step=%0d sw=%0b cfg=%0b expected 0 0 1 0 0",
                     wave_sel, amp_shift, phase_step, sweep_active, cfg_update);
        end
    endtask

    task automatic test_key1;
        int lat = 0;
        cfg_pulses = 0;
        key1 = 1'b0;
        while (wave_sel == 2'd0 && lat < 20) begin
            step_clk(1);
            lat++;
        end
        n_tests++;
        if (lat != 2 + DEB_CNT + 1) begin
            n_fail++;
            $display("FAIL key1_latency: got %0d edges expected %0d", lat, 2 + DEB_CNT + 1);
        end
        step_clk(2);
        key1 = 1'b1;
        step_clk(12);
        model_press(3'b001);
        n_tests++;
        if (wave_sel !== 2'(m_wave) || cfg_pulses != 1) begin
            n_fail++;
            $display("FAIL key1_press0: got ws=%0d pulses=%0d expected ws=%0d pulses=1", wave_sel, cfg_pulses, m_wave);
        end
        for (int i = 1; i < 5; i++) begin
            cfg_pulses = 0;
            do_press(3'b001, $urandom_range(5, 9), $urandom_range(10, 14));
            model_press(3'b001);
            n_tests++;
            if (wave_sel !== 2'(m_wave) || cfg_pulses != 1) begin
                n_fail++;
                $display("FAIL key1_press%0d: got ws=%0d pulses=%0d expected ws=%0d pulses=1",
                         i, wave_sel, cfg_pulses, m_wave);
            end
        end
    endtask

    task automatic test_key2_glitch;
        cfg_pulses = 0;
        do_press(3'b010, DEB_CNT - 1, 12);
        n_tests++;
        if (amp_shift !== 3'(m_amp) || cfg_pulses != 0) begin
            n_fail++;
            $display("FAIL key2_glitch: got amp=%0d pulses=%0d expected amp=%0d pulses=0", amp_shift, cfg_pulses, m_amp);
        end
        for (int i = 0; i < 4; i++) begin
            cfg_pulses = 0;
            do_press(3'b010, $urandom_range(5, 9), $urandom_range(10, 14));
            model_press(3'b010);
            n_tests++;
            if (amp_shift !== 3'(m_amp) || cfg_pulses != 1) begin
                n_fail++;
                $display("FAIL key2_press%0d: got amp=%0d pulses=%0d expected amp=%0d pulses=1",
                         i, amp_shift, cfg_pulses, m_amp);
            end
        end
    endtask

    task automatic test_key3_short;
        sweep_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_pulses = 0;
            do_press(3'b100, 6, 12);
            model_press(3'b100);
            n_tests++;
            if (phase_step !== 8'(m_step) || cfg_pulses != 1) begin
                n_fail++;
                $display("FAIL key3_short%0d: got step=%0d pulses=%0d expected step=%0d pulses=1",
                         i, phase_step, cfg_pulses, m_step);
            end
        end
        n_tests++;
        if (sweep_seen) begin
            n_fail++;
            $display("FAIL key3_short_no_sweep: got sweep_active=1 expected 0");
        end
    endtask

    task automatic test_back_to_back;
        int lat = 0;
        int exp_w = (m_wave + 1) % 4;
        int exp_a = (m_amp == AMP_MAX) ? 0 : m_amp + 1;
        logic [1:0] ws0 = wave_sel;
        cfg_pulses = 0;
        key1 = 1'b0; key2 = 1'b0;
        while (wave_sel == ws0 && lat < 20) begin
            step_clk(1);
            lat++;
        end
        n_tests++;
        if (wave_sel !== 2'(exp_w) || amp_shift !== 3'(exp_a)) begin
            n_fail++;
            $display("FAIL simul_same_edge: got ws=%0d amp=%0d expected ws=%0d amp=%0d", wave_sel, amp_shift, exp_w, exp_a);
        end
        step_clk(3);
        key1 = 1'b1; key2 = 1'b1;
        step_clk(12);
        model_press(3'b011);
        n_tests++;
        if (cfg_pulses != 1) begin
            n_fail++;
            $display("FAIL simul_cfg_pulse: got %0d pulses expected 1", cfg_pulses);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [2:0] mask = 3'($urandom_range(1, 7));
            bit glitch = ($urandom_range(0, 3) == 0);
            int exp_p;
            cfg_pulses = 0;
            if (glitch) begin
                do_press(mask, $urandom_range(1, DEB_CNT - 1), $urandom_range(6, 10));
                exp_p = 0;
            end else begin
                do_press(mask, $urandom_range(5, 10), $urandom_range(10, 14));
                model_press(mask);
                exp_p = ((mask[0] | mask[1]) ? 1 : 0) + (mask[2] ? 1 : 0);
            end
            n_tests++;
            if ({wave_sel, amp_shift, phase_step} !== {2'(m_wave), 3'(m_amp), 8'(m_step)} || cfg_pulses != exp_p) begin
                n_fail++;
                $display("FAIL random%0d mask=%b glitch=%0b: got ws=%0d amp=%0d step=%0d pulses=%0d expected %0d %0d %0d %0d",
                         i, mask, glitch, wave_sel, amp_shift, phase_step, cfg_pulses, m_wave, m_amp, m_step, exp_p);
            end
        end
    endtask

    task automatic test_sweep;
        int lat = 0;
        int fall_t = 0;
        int frozen;
        while (m_step != 1) begin
            do_press(3'b100, 6, 12);
            model_press(3'b100);
        end
        n_tests++;
        if (phase_step !== 8'd1) begin
            n_fail++;
            $display("FAIL sweep_start_step: got %0d expected 1", phase_step);
        end
        key3 = 1'b0;
        while (!sweep_active && lat < 40) begin
            step_clk(1);
            lat++;
        end
        n_tests++;
        if (!sweep_active || lat < DEB_CNT + LONG_CNT + 1 || lat > DEB_CNT + LONG_CNT + 5) begin
            n_fail++;
            $display("FAIL sweep_long_event: got sweep_active=%0b after %0d edges expected 1 after %0d..%0d",
                     sweep_active, lat, DEB_CNT + LONG_CNT + 1, DEB_CNT + LONG_CNT + 5);
        end
        // Release the long press, tap a short press mid-sweep, then long-press to stop
        for (int t = 1; t <= 120; t++) begin
            if (t == 7 || t == 26) key3 = 1'b1;
            if (t == 20 || t == 60) key3 = 1'b0;
            step_clk(1);
            if (!sweep_active) begin
                fall_t = t;
                break;
            end
            n_tests++;
            if (phase_step !== 8'(sweep_model(t))) begin
                n_fail++;
                $display("FAIL sweep_step t=%0d: got %0d expected %0d", t, phase_step, sweep_model(t));
            end
        end
        n_tests++;
        if (fall_t < 60 + DEB_CNT + LONG_CNT || fall_t > 60 + DEB_CNT + LONG_CNT + 4) begin
            n_fail++;
            $display("FAIL sweep_stop: got stop at t=%0d expected %0d..%0d",
                     fall_t, 60 + DEB_CNT + LONG_CNT, 60 + DEB_CNT + LONG_CNT + 4);
        end
        frozen = sweep_model(fall_t - 1);
        step_clk(4);
        key3 = 1'b1;
        cfg_pulses = 0;
        step_clk(40);
        m_step = frozen;
        n_tests++;
        if (phase_step !== 8'(frozen) || sweep_active !== 1'b0 || cfg_pulses != 0) begin
            n_fail++;
            $display("FAIL sweep_frozen: got step=%0d sw=%0b pulses=%0d expected step=%0d sw=0 pulses=0",
                     phase_step, sweep_active, cfg_pulses, frozen);
        end
    endtask

    task automatic test_reset_in_sweep;
        int lat = 0;
        key3 = 1'b0;
        while (!sweep_active && lat < 40) begin
            step_clk(1);
            lat++;
        end
        step_clk(10);
        #2 rst_n = 1'b0;
        #1;
        m_wave = 0; m_amp = 0; m_step = 1;
        n_tests++;
        if ({wave_sel, amp_shift, phase_step, sweep_active, cfg_update} !== {2'd0, 3'd0, 8'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got ws=%0d amp=%0d step=%0d sw=%0b cfg=%0b expected 0 0 1 0 0",
                     wave_sel, amp_shift, phase_step, sweep_active, cfg_update);
        end
        step_clk(2);
        rst_n = 1'b1;
        lat = 0;
        while (!sweep_active && lat < 40) begin
            step_clk(1);
            lat++;
        end
        n_tests++;
        if (!sweep_active || lat < DEB_CNT + LONG_CNT + 1 || lat > DEB_CNT + LONG_CNT + 5) begin
            n_fail++;
            $display("FAIL reset_held_long: got sweep_active=%0b after %0d edges expected 1 after %0d..%0d",
                     sweep_active, lat, DEB_CNT + LONG_CNT + 1, DEB_CNT + LONG_CNT + 5);
        end
        n_tests++;
        if ({wave_sel, amp_shift, phase_step} !== {2'(m_wave), 3'(m_amp), 8'(m_step)}) begin
            n_fail++;
            $display("FAIL reset_held_regs: got ws=%0d amp=%0d step=%0d expected 0 0 1", wave_sel, amp_shift, phase_step);
        end
        key3 = 1'b1;
        step_clk(4);
    endtask

    initial begin
        test_reset;
        test_key1;
        test_key2_glitch;
        test_key3_short;
        test_back_to_back;
        test_random;
        test_sweep;
        test_reset_in_sweep;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_ctrl.md
# wave_ctrl

Key-driven configuration controller for the four-waveform ROM generator. It debounces the three user keys and owns the generator's control registers: waveform select, output amplitude shift and phase-accumulator step. It also runs an automatic frequency-sweep sequencer on the phase step. Its outputs drive the ROM output mux, the output right-shifter and the address accumulator increment directly.

## Interface

Parameters:
- DEB_CNT, 1000000: cycles a synchronized key level must stay stable before it is accepted (20 ms at 50 MHz).
- LONG_CNT, 50000000: cycles key3 must be held after acceptance to count as a long press.
- SWEEP_DWELL, 5000000: cycles per phase-step change while sweeping.
- STEP_MAX, 16: maximum phase step; range 2..255.
- AMP_MAX, 4: maximum amplitude shift; range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key1  in  1  waveform-select key, active-low, asynchronous to clk
- key2  in  1  amplitude key, active-low, asynchronous
- key3  in  1  step/sweep key, active-low, asynchronous
- wave_sel  out  2  0 = sin, 1 = square, 2 = sawtooth, 3 = triangular
- amp_shift  out  3  right-shift applied to the waveform sample
- phase_step  out  8  address increment per clk
- sweep_active  out  1  high while the sweep FSM is in UP or DOWN
- cfg_update  out  1  one-cycle pulse in the cycle after any of wave_sel, amp_shift or phase_step changes

## Operation

- Each key passes through a 2-FF synchronizer and then a debouncer.
  - The debouncer holds an accepted level, reset to 1 (released).
  - A counter runs while the synchronized level differs from the accepted level. It clears whenever the two match.
  - When the counter reaches DEB_CNT-1 with the level still differing, the accepted level flips.
- A press event is a 1->0 transition of the accepted level. A release event is a 0->1 transition.
- key1 press: wave_sel <= wave_sel+1, mod 4.
- key2 press: amp_shift <= amp_shift+1. It wraps from AMP_MAX to 0.
- key3 handling:
  - A hold counter starts on the key3 press event.
  - If the counter reaches LONG_CNT-1 while key3 is still accepted low, a long event fires once. The event fires at that moment, not at release.
  - A release event with no long event fired is a short event.
  - The release that follows a long event produces nothing.
- Short event in IDLE: phase_step <= phase_step+1, wrapping from STEP_MAX to 1. phase_step is never 0. Short events are ignored in UP and DOWN.
- Sweep FSM:
  - States are IDLE, UP and DOWN. A dwell counter clears on entry to UP.
  - IDLE -> UP on a long event.
  - UP: phase_step+1 each time the dwell counter reaches SWEEP_DWELL-1. On reaching STEP_MAX, go to DOWN.
  - DOWN: phase_step-1 at the same dwell rate. On reaching 1, go to UP.
  - UP or DOWN -> IDLE on a long event. phase_step holds its current value.
- The three key paths are independent. Events in the same cycle on different keys are all applied in that cycle.
- All arithmetic uses the output register widths. Wrap points are the explicit compares above, not overflow.

## Timing

- Reset values:
  - wave_sel = 0, amp_shift = 0, phase_step = 1.
  - sweep_active = 0, cfg_update = 0, FSM = IDLE.
  - Debouncers accept 1 and all counters are 0.
- Reset mid-press or mid-sweep returns everything to the reset values immediately. A key still held after rst_n deasserts produces a press event DEB_CNT cycles after the synchronizer output goes low.
- Latency:
  - A key pin driven low reaches the synchronized level after 2 clk edges.
  - The accepted level flips after DEB_CNT further edges of stable level.
  - The affected output register updates on the next edge.
  - cfg_update is high for the cycle after that.
- Glitches shorter than DEB_CNT cycles produce no event.
- sweep_active is registered. It goes high on the same edge the FSM enters UP and low on the edge it enters IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use DEB_CNT=4, LONG_CNT=16, SWEEP_DWELL=8, STEP_MAX=4, AMP_MAX=2.

- Reset, then 5 clean key1 presses -> wave_sel reads 1,2,3,0,1. cfg_update pulses once per press.
- key2 low for 3 cycles only (glitch) -> no change. Then 4 clean presses -> amp_shift reads 1,2,0,1.
- 4 short key3 presses (held 6 cycles each) -> phase_step reads 2,3,4,1. sweep_active stays 0.
- key3 held 30 cycles:
  - Long event fires; sweep_active=1.
  - phase_step steps 1->2->3->4->3->2->1->2 every 8 cycles.
  - A short key3 press during the sweep has no effect.
  - A second long press -> IDLE with phase_step frozen.
- key1 and key2 pressed in the same cycle -> wave_sel and amp_shift both increment on the same edge, with a single cfg_update pulse.
- Assert rst_n low during a sweep with key3 held, then release it -> all outputs at reset values. One key3 press event follows after 4 stable cycles, and a long event at hold count 16.
